// File: rtl/manch_pkg.sv
// Shared Manchester line definitions: FSM states, idle line level and
// half-bit period helper. Used by both the encoder and the decoder.
package manch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } manch_state_e;

  localparam logic LINE_IDLE = 1'b0;

  // Clock cycles per half-bit; BAUDRATE counts half-bits per second.
  function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                              input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/manch_half_tick.sv
// Half-bit timebase: counts 0..HALF-1 and wraps, pulsing tick on the last
// count. restart forces the count back to 0 so a frame starts phase-aligned.
module manch_half_tick #(
  parameter int unsigned HALF = 81
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap/restart decode and next count.
  always_comb begin
    tick = (cnt_q == CW'(HALF - 1));
    if (restart || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/manch_encoder.sv
// Manchester transmitter (IEEE 802.3 polarity: mid-bit rise = 1, fall = 0).
// Frame: START(1), 8 data bits LSB first, optional even parity, 2-half gap.
// Build option: define MANCH_PARITY_EN to insert the even-parity bit.
module manch_encoder
  import manch_pkg::*;
#(
  parameter int unsigned BAUDRATE = 230400,
  parameter int unsigned CLK_FREQ = 18_750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       manch_out
);

  localparam int unsigned HALF = half_cycles(CLK_FREQ, BAUDRATE);

  manch_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   shift_q, shift_d;
  logic         manch_q, manch_d;
  logic         done_q, done_d;
  logic         accept;
  logic         tick;
  logic         last_half;
  logic         bit_val;
`ifdef MANCH_PARITY_EN
  logic         par_q, par_d;
`endif

  assign tx_ready  = (state_q == IDLE);
  assign tx_busy   = ~tx_ready;
  assign tx_done   = done_q;
  assign manch_out = manch_q;
  assign accept    = tx_valid && tx_ready;

  manch_half_tick #(.HALF(HALF)) u_half_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  // Next-state, half index, shift register and frame-end pulse.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    last_half = (state_q == DATA) ? (idx_q == 4'd15) : (idx_q == 4'd1);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          idx_d   = '0;
          shift_d = tx_data;
        end
      end
      START: begin
        if (tick) begin
          idx_d = last_half ? 4'd0 : idx_q + 4'd1;
          if (last_half) state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q[0]) shift_d = shift_q >> 1;
          idx_d = last_half ? 4'd0 : idx_q + 4'd1;
`ifdef MANCH_PARITY_EN
          if (last_half) state_d = PARITY;
`else
          if (last_half) state_d = GAP;
`endif
        end
      end
`ifdef MANCH_PARITY_EN
      PARITY: begin
        if (tick) begin
          idx_d = last_half ? 4'd0 : idx_q + 4'd1;
          if (last_half) state_d = GAP;
        end
      end
`endif
      GAP: begin
        if (tick) begin
          idx_d = last_half ? 4'd0 : idx_q + 4'd1;
          if (last_half) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Line level for the current half: ~b in the first half, b in the second.
  always_comb begin
    bit_val = 1'b0;
    manch_d = LINE_IDLE;
    case (state_q)
      START: begin
        bit_val = 1'b1;
        manch_d = idx_q[0] ? bit_val : ~bit_val;
      end
      DATA: begin
        bit_val = shift_q[0];
        manch_d = idx_q[0] ? bit_val : ~bit_val;
      end
`ifdef MANCH_PARITY_EN
      PARITY: begin
        bit_val = par_q;
        manch_d = idx_q[0] ? bit_val : ~bit_val;
      end
`endif
      default: manch_d = LINE_IDLE;
    endcase
  end

  // State, data and line registers; reset drops the line and any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      manch_q <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      manch_q <= manch_d;
      done_q  <= done_d;
    end
  end

`ifdef MANCH_PARITY_EN
  // Even parity of the accepted byte, captured with the data.
  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^tx_data;
  end

  // Parity register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_manch_encoder.sv
// Directed bench for manch_encoder: HALF=10 instance plus a default-rate one.
module tb_manch_encoder;

  localparam int unsigned H   = 10;
  localparam int unsigned H81 = 81;
`ifdef MANCH_PARITY_EN
  localparam int unsigned NH = 22;
  localparam logic [0:21] EXP_A5 = 22'b01_0110011010011001_10_00;
  localparam logic [0:21] EXP_FF = 22'b01_0101010101010101_10_00;
  localparam logic [0:21] EXP_07 = 22'b01_0101011010101010_01_00;
`else
  localparam int unsigned NH = 20;
  localparam logic [0:21] EXP_A5 = 22'b01_0110011010011001_00_00;
  localparam logic [0:21] EXP_FF = 22'b01_0101010101010101_00_00;
  localparam logic [0:21] EXP_07 = 22'b01_0101011010101010_00_00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, manch_out;
  logic [7:0] tx_data81;
  logic       tx_valid81;
  logic       tx_ready81, tx_busy81, tx_done81, manch_out81;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  manch_encoder #(.BAUDRATE(100), .CLK_FREQ(1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .manch_out (manch_out)
  );

  manch_encoder dut81 (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data81),
    .tx_valid  (tx_valid81),
    .tx_ready  (tx_ready81),
    .tx_busy   (tx_busy81),
    .tx_done   (tx_done81),
    .manch_out (manch_out81)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Half-bit line levels for a byte: start, data LSB first, [parity], gap.
  function automatic logic [0:21] model(input logic [7:0] b);
    logic [0:21] v;
    v = '0;
    v[0] = 1'b0;
    v[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v[2 + 2*i] = ~b[i];
      v[3 + 2*i] = b[i];
    end
`ifdef MANCH_PARITY_EN
    v[18] = ~(^b);
    v[19] = ^b;
`endif
    return v;
  endfunction

  // Caller has tx_valid high and the encoder ready; the next edge accepts.
  task automatic run_frame(input bit sel, input int unsigned h, input logic [0:21] exp,
                           input bit hold, input logic [7:0] next_data, input string tag);
    int unsigned len;
    logic o_line, o_done, o_rdy, o_busy;
    len = NH * h;
    @(posedge clk); #1;
    o_rdy  = sel ? tx_ready81 : tx_ready;
    o_busy = sel ? tx_busy81  : tx_busy;
    chk({tag, "_ready_after_accept"}, o_rdy, 0);
    chk({tag, "_busy_after_accept"}, o_busy, 1);
    if (sel) begin
      tx_data81 = next_data;
      if (!hold) tx_valid81 = 1'b0;
    end else begin
      tx_data = next_data;
      if (!hold) tx_valid = 1'b0;
    end
    for (int unsigned k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      o_line = sel ? manch_out81 : manch_out;
      o_done = sel ? tx_done81   : tx_done;
      chk({tag, "_line"}, o_line, exp[(k - 1) / h]);
      chk({tag, "_done"}, o_done, (k == len));
    end
    o_rdy  = sel ? tx_ready81 : tx_ready;
    o_busy = sel ? tx_busy81  : tx_busy;
    chk({tag, "_ready_at_done"}, o_rdy, 1);
    chk({tag, "_busy_at_done"}, o_busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    tx_data81  = 8'h00;
    tx_valid81 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", manch_out, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_line81", manch_out81, 0);
    chk("rst_ready81", tx_ready81, 1);
    rst = 1'b0;

    // Idle with no valid.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      chk("idle_line", manch_out, 0);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", tx_busy, 0);
    end

    // Byte 0xA5, tx_data scrambled after accept.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    run_frame(1'b0, H, EXP_A5, 1'b0, 8'h5A, "a5");

    // Back-to-back 0x00 then 0xFF with valid held high throughout.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    run_frame(1'b0, H, model(8'h00), 1'b1, 8'hFF, "b2b0");
    run_frame(1'b0, H, EXP_FF, 1'b0, 8'h00, "b2b1");

    // Reset at cycle 75 of a 0x3C frame.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (74) @(posedge clk);
    #1;
    chk("mid_line_before_rst", manch_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_line_rst", manch_out, 0);
    chk("mid_ready_rst", tx_ready, 1);
    chk("mid_busy_rst", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", tx_done, 0);
      chk("post_rst_line", manch_out, 0);
    end
    chk("post_rst_ready", tx_ready, 1);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    run_frame(1'b0, H, model(8'h3C), 1'b0, 8'h00, "x3c");

    // Byte 0x07 (parity bit 1 when enabled).
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    run_frame(1'b0, H, EXP_07, 1'b0, 8'h00, "x07");

    // Default rate instance, byte 0x01.
    tx_data81  = 8'h01;
    tx_valid81 = 1'b1;
    run_frame(1'b1, H81, model(8'h01), 1'b0, 8'h00, "d81");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/manch_encoder.md
Name: manch_encoder

Overview:
- Manchester transmitter. It serialises one byte per frame onto a single line using IEEE 802.3 polarity: mid-bit rising edge = 1, mid-bit falling edge = 0.
- It is the transmit-side counterpart of the team's Manchester decoder. Line timing uses the same half-bit rate convention, where BAUDRATE counts half-bits per second.
- Byte source is a valid/ready streaming interface. Output drives the line pin directly.

Parameters:
- BAUDRATE, 230400, half-bit rate in Hz (2 × 115200 bit rate).
- CLK_FREQ, 18_750_000, clk frequency in Hz.
- HALF (localparam), CLK_FREQ/BAUDRATE with integer truncation, clk cycles per half-bit; 81 at defaults. HALF must be ≥ 2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  byte to send; sampled on accept.
- tx_valid  in  1  byte available.
- tx_ready  out  1  encoder can accept a byte.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at the end of the frame gap.
- manch_out  out  1  encoded line, registered.

Behaviour:
- Reset values: manch_out=0 (idle low), tx_ready=1, tx_busy=0, tx_done=0. Half counter=0, state=IDLE.
- Reset asserted mid-frame: line forced low and state forced to IDLE immediately (asynchronously); the partial frame is discarded.
- Accept: the handshake completes on a clk edge with tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - tx_ready falls and tx_busy rises in the cycle after the accept edge.
- Frame, in order:
  - START bit with value 1.
  - 8 data bits, LSB first.
  - Parity bit, only if MANCH_PARITY_EN is defined.
  - GAP of one full bit period (2 half-bits) with the line held low.
- Encoding of each bit b: first half drives ~b, second half drives b. Each half lasts exactly HALF cycles.
- manch_out changes on the clk edge after accept and then every HALF cycles. There is no jitter, since the counter is free of input dependence.
- Half counter: counts 0..HALF-1 and wraps. Its wrap is the half-tick that advances the half index.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after 2 half-ticks.
  - DATA → PARITY (or GAP) after 16 half-ticks.
  - PARITY → GAP after 2 half-ticks.
  - GAP → IDLE after 2 half-ticks.
- Exit from GAP: tx_done pulses for one cycle, coincident with the return to IDLE. tx_ready=1 and tx_busy=0 in that same cycle.
- Back-to-back frames: a byte may be accepted in the cycle tx_ready returns high. The next START then begins one cycle later, so the minimum inter-frame gap is 2·HALF+1 cycles.
- Frame length from accept to tx_done, no parity: 20·HALF cycles, i.e. 1620 at defaults.
- tx_valid while busy: ignored; the source must hold it until tx_ready.
- tx_data changes after accept: no effect on the frame in progress.

Optional Feature:
- MANCH_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) is inserted after bit 7 and encoded like any other bit. Frame grows to 22·HALF cycles.
- MANCH_PARITY_EN undefined: no parity state, and DATA goes directly to GAP.

Decomposition:
- Package manch_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, GAP);
  - the LINE_IDLE=1'b0 constant;
  - the function half_cycles(CLK_FREQ, BAUDRATE).
  - The decoder shares the package.
- Sub-module manch_half_tick: parameterised HALF counter with a restart input (pulsed on accept) and a one-cycle tick output.

Test Plan (CLK_FREQ=1000, BAUDRATE=100 → HALF=10, unless noted):
- Reset idle: rst high then low, no valid → manch_out=0, tx_ready=1, tx_busy=0 for 500 cycles.
- Byte 0xA5: accept → half-bit line sequence 0,1 | 0,1 1,0 0,1 1,0 1,0 0,1 1,0 0,1 | 0,0, each half 10 cycles. tx_done pulses exactly 200 cycles after accept.
- Back-to-back 0x00 then 0xFF, valid held high → second START begins 21 cycles after the first frame's last data half ends. 0xFF data halves are all 0,1.
- Reset mid-frame: assert rst at cycle 75 of 0x3C → manch_out=0 the same cycle, no tx_done. After release, tx_ready=1 and a new 0x3C frame is bit-exact.
- Defaults (HALF=81), byte 0x01 → first edge 1 cycle after accept, mid-bit edges spaced 81 cycles, tx_done at 1620 cycles.
- With MANCH_PARITY_EN, byte 0x07 → parity bit 1, encoded as halves 0,1 before the gap. tx_done at 220 cycles.
